// File: rtl/fetch_phase.sv
// Instruction-fetch stage: drives instruction memory with the issued PC,
// tracks in-flight read validity across the fixed memory latency, pairs each
// returning word with its PC in one output register, and raises stall_pc when
// decode refuses the held instruction (in-flight reads are then dropped and
// the PC unit replays them). flush drops all work and wins over everything.
module fetch_phase #(
    parameter int LOAD_LATENCY = 1,
    parameter int ADDR_W       = 32,
    parameter int INST_W       = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_to_mem,
    input  logic [ADDR_W-1:0] pc_to_fet,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              de_ready,
    output logic              fd_valid,
    output logic [ADDR_W-1:0] fd_pc,
    output logic [INST_W-1:0] fd_inst,
    output logic              stall_pc,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_replays
);

    // vq_q[i] marks the read issued i+1 cycles ago as one decode should see
    logic [LOAD_LATENCY-1:0] vq_q, vq_d;
    logic                    fd_valid_q, fd_valid_d;
    logic [ADDR_W-1:0]       fd_pc_q, fd_pc_d;
    logic [INST_W-1:0]       fd_inst_q, fd_inst_d;
    logic                    stall_pc_q;
    logic [31:0]             perf_fetched_q, perf_fetched_d;
    logic [31:0]             perf_replays_q, perf_replays_d;

    logic stall;
    logic accept;
    logic stall_rise;

    // Handshake decode: stall only when a valid word is refused and no flush
    always_comb begin
        stall      = fd_valid_q & ~de_ready & ~flush;
        accept     = fd_valid_q & de_ready & ~flush;
        stall_rise = stall & ~stall_pc_q;
    end

    // Valid pipe: a stall or flush kills every in-flight read so it is replayed
    always_comb begin
        vq_d = vq_q;
        if (flush || stall) begin
            vq_d = '0;
        end else begin
            vq_d[0] = 1'b1;
            for (int i = 1; i < LOAD_LATENCY; i++) begin
                vq_d[i] = vq_q[i-1];
            end
        end
    end

    // Output register: PC and data captured every free cycle, even when invalid
    always_comb begin
        fd_valid_d = fd_valid_q;
        fd_pc_d    = fd_pc_q;
        fd_inst_d  = fd_inst_q;
        if (flush) begin
            fd_valid_d = 1'b0;
        end else if (!stall) begin
            fd_valid_d = vq_q[LOAD_LATENCY-1];
            fd_pc_d    = pc_to_fet;
            fd_inst_d  = mem_rdata;
        end
    end

    // Performance counters, free-running and wrapping
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_replays_d = perf_replays_q;
        if (accept) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (stall_rise) begin
            perf_replays_d = perf_replays_q + 32'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vq_q           <= '0;
            fd_valid_q     <= 1'b0;
            fd_pc_q        <= '0;
            fd_inst_q      <= '0;
            stall_pc_q     <= 1'b0;
            perf_fetched_q <= '0;
            perf_replays_q <= '0;
        end else begin
            vq_q           <= vq_d;
            fd_valid_q     <= fd_valid_d;
            fd_pc_q        <= fd_pc_d;
            fd_inst_q      <= fd_inst_d;
            stall_pc_q     <= stall;
            perf_fetched_q <= perf_fetched_d;
            perf_replays_q <= perf_replays_d;
        end
    end

    // Output drive; memory address is a straight pass-through of the issued PC
    always_comb begin
        mem_addr     = pc_to_mem;
        fd_valid     = fd_valid_q;
        fd_pc        = fd_pc_q;
        fd_inst      = fd_inst_q;
        stall_pc     = stall;
        perf_fetched = perf_fetched_q;
        perf_replays = perf_replays_q;
    end

endmodule

// File: tb/tb_fetch_phase.sv
// Directed bench for fetch_phase at load latencies 2, 1 and 4. The bench
// plays the PC unit (RIP, frozen-on-stall PC queue, flush redirect) and the
// instruction memory (data = 0x100 + address, fixed latency).
module tb_fetch_phase;

    logic clk;

    logic        rstn_a[3];
    logic        flush_a[3];
    logic        de_ready_a[3];
    logic [31:0] pc_to_mem_a[3];
    logic [31:0] pc_to_fet_a[3];
    logic [31:0] mem_addr_a[3];
    logic [63:0] mem_rdata_a[3];
    logic        fd_valid_a[3];
    logic [31:0] fd_pc_a[3];
    logic [63:0] fd_inst_a[3];
    logic        stall_a[3];
    logic [31:0] perf_fetched_a[3];
    logic [31:0] perf_replays_a[3];

    // PC unit / memory model state
    int          lat[3];
    logic [31:0] rip[3];
    logic [31:0] redir[3];
    logic [31:0] pq[3][5];
    logic [31:0] ah[3][5];

    int errors = 0;
    int checks = 0;
    int cur_lat = 0;

    fetch_phase #(.LOAD_LATENCY(2), .ADDR_W(32), .INST_W(64)) u_l2 (
        .clk(clk), .rstn(rstn_a[0]), .pc_to_mem(pc_to_mem_a[0]), .pc_to_fet(pc_to_fet_a[0]),
        .flush(flush_a[0]), .mem_addr(mem_addr_a[0]), .mem_rdata(mem_rdata_a[0]),
        .de_ready(de_ready_a[0]), .fd_valid(fd_valid_a[0]), .fd_pc(fd_pc_a[0]),
        .fd_inst(fd_inst_a[0]), .stall_pc(stall_a[0]), .perf_fetched(perf_fetched_a[0]),
        .perf_replays(perf_replays_a[0]));

    fetch_phase #(.LOAD_LATENCY(1), .ADDR_W(32), .INST_W(64)) u_l1 (
        .clk(clk), .rstn(rstn_a[1]), .pc_to_mem(pc_to_mem_a[1]), .pc_to_fet(pc_to_fet_a[1]),
        .flush(flush_a[1]), .mem_addr(mem_addr_a[1]), .mem_rdata(mem_rdata_a[1]),
        .de_ready(de_ready_a[1]), .fd_valid(fd_valid_a[1]), .fd_pc(fd_pc_a[1]),
        .fd_inst(fd_inst_a[1]), .stall_pc(stall_a[1]), .perf_fetched(perf_fetched_a[1]),
        .perf_replays(perf_replays_a[1]));

    fetch_phase #(.LOAD_LATENCY(4), .ADDR_W(32), .INST_W(64)) u_l4 (
        .clk(clk), .rstn(rstn_a[2]), .pc_to_mem(pc_to_mem_a[2]), .pc_to_fet(pc_to_fet_a[2]),
        .flush(flush_a[2]), .mem_addr(mem_addr_a[2]), .mem_rdata(mem_rdata_a[2]),
        .de_ready(de_ready_a[2]), .fd_valid(fd_valid_a[2]), .fd_pc(fd_pc_a[2]),
        .fd_inst(fd_inst_a[2]), .stall_pc(stall_a[2]), .perf_fetched(perf_fetched_a[2]),
        .perf_replays(perf_replays_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (L=%0d): observed=%0h expected=%0h", tag, cur_lat, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 3; k++) begin
            pc_to_mem_a[k] = rip[k];
            pc_to_fet_a[k] = pq[k][lat[k]];
            mem_rdata_a[k] = 64'h100 + {32'd0, ah[k][lat[k]]};
        end
    endtask

    // One clock: sample control mid-cycle, advance the PC unit and memory after the edge
    task automatic tick();
        logic st[3];
        logic fl[3];
        logic rs[3];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            st[k] = stall_a[k];
            fl[k] = flush_a[k];
            rs[k] = rstn_a[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 4; j >= 2; j--) ah[k][j] = ah[k][j-1];
            ah[k][1] = rip[k];
            if (rs[k] !== 1'b1) begin
                rip[k] = '0;
                for (int j = 0; j < 5; j++) pq[k][j] = '0;
            end else if (st[k] === 1'b1 && fl[k] !== 1'b1) begin
                rip[k] = pq[k][lat[k]];
            end else begin
                for (int j = 4; j >= 2; j--) pq[k][j] = pq[k][j-1];
                pq[k][1] = rip[k];
                rip[k] = (fl[k] === 1'b1) ? redir[k] : rip[k] + 32'd1;
            end
        end
        drive();
    endtask

    task automatic run_basic(input int k);
        int L;
        L = lat[k];
        cur_lat = L;

        // Reset, then linear fetch with decode always ready
        rstn_a[k] = 1'b0; de_ready_a[k] = 1'b1; flush_a[k] = 1'b0;
        tick(); tick();
        rstn_a[k] = 1'b1;
        #1;
        chk("rst_valid", fd_valid_a[k], 0);
        chk("rst_pc", fd_pc_a[k], 0);
        chk("rst_inst", fd_inst_a[k], 0);
        chk("rst_fetched", perf_fetched_a[k], 0);
        chk("rst_replays", perf_replays_a[k], 0);
        chk("rst_stall", stall_a[k], 0);
        chk("mem_addr", mem_addr_a[k], rip[k]);
        for (int c = 1; c <= L + 5; c++) begin
            tick();
            if (c <= L) begin
                chk("s1_bubble", fd_valid_a[k], 0);
            end else begin
                chk("s1_valid", fd_valid_a[k], 1);
                chk("s1_pc", fd_pc_a[k], c - L - 1);
                chk("s1_inst", fd_inst_a[k], 64'h100 + c - L - 1);
            end
        end
        chk("s1_fetched", perf_fetched_a[k], 4);

        // Decode refuses pc 4 for three cycles
        de_ready_a[k] = 1'b0;
        #1;
        chk("s2_stall_on", stall_a[k], 1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("s2_hold_valid", fd_valid_a[k], 1);
            chk("s2_hold_pc", fd_pc_a[k], 4);
            chk("s2_hold_inst", fd_inst_a[k], 64'h104);
            if (c < 3) chk("s2_stall", stall_a[k], 1);
        end
        chk("s2_replays", perf_replays_a[k], 1);
        de_ready_a[k] = 1'b1;
        #1;
        chk("s2_stall_off", stall_a[k], 0);
        for (int c = 1; c <= L + 1; c++) begin
            tick();
            if (c == 1) chk("s2_fetched", perf_fetched_a[k], 5);
            if (c <= L) begin
                chk("s2_bubble", fd_valid_a[k], 0);
            end else begin
                chk("s2_valid", fd_valid_a[k], 1);
                chk("s2_pc", fd_pc_a[k], 5);
                chk("s2_inst", fd_inst_a[k], 64'h105);
            end
        end
        tick();
        chk("s2_pc6", fd_pc_a[k], 6);
        tick();
        chk("s2_pc7", fd_pc_a[k], 7);
        chk("s2_valid7", fd_valid_a[k], 1);

        // Flush while holding pc 7, PC unit redirects to 0x40
        flush_a[k] = 1'b1; redir[k] = 32'h40;
        tick();
        flush_a[k] = 1'b0;
        chk("fl_valid", fd_valid_a[k], 0);
        chk("fl_fetched", perf_fetched_a[k], 7);
        for (int c = 2; c <= L + 2; c++) begin
            tick();
            if (c <= L + 1) begin
                chk("fl_bubble", fd_valid_a[k], 0);
            end else begin
                chk("fl_valid40", fd_valid_a[k], 1);
                chk("fl_pc40", fd_pc_a[k], 32'h40);
                chk("fl_inst40", fd_inst_a[k], 64'h140);
            end
        end
        tick();
        chk("fl_pc41", fd_pc_a[k], 32'h41);
        chk("fl_inst41", fd_inst_a[k], 64'h141);

        // Flush together with decode not ready: flush wins, no replay
        flush_a[k] = 1'b1; de_ready_a[k] = 1'b0; redir[k] = 32'h80;
        #1;
        chk("fn_stall", stall_a[k], 0);
        tick();
        flush_a[k] = 1'b0; de_ready_a[k] = 1'b1;
        chk("fn_valid", fd_valid_a[k], 0);
        chk("fn_replays", perf_replays_a[k], 1);
        chk("fn_fetched", perf_fetched_a[k], 8);
        for (int c = 2; c <= L + 2; c++) begin
            tick();
            if (c <= L + 1) chk("fn_bubble", fd_valid_a[k], 0);
        end
        chk("fn_pc80", fd_pc_a[k], 32'h80);
        chk("fn_valid80", fd_valid_a[k], 1);

        // Second stall episode, one ready cycle, then not-ready over bubbles
        de_ready_a[k] = 1'b0;
        tick();
        chk("bb_hold", fd_pc_a[k], 32'h80);
        chk("bb_replays2", perf_replays_a[k], 2);
        de_ready_a[k] = 1'b1;
        #1;
        chk("bb_ready_stall", stall_a[k], 0);
        tick();
        de_ready_a[k] = 1'b0;
        #1;
        chk("bb_bubble_valid", fd_valid_a[k], 0);
        chk("bb_bubble_stall", stall_a[k], 0);
        for (int c = 3; c <= L + 2; c++) begin
            tick();
            if (c <= L + 1) begin
                chk("bb_bubble", fd_valid_a[k], 0);
                chk("bb_nostall", stall_a[k], 0);
            end
        end
        chk("bb_pc81", fd_pc_a[k], 32'h81);
        chk("bb_stall3", stall_a[k], 1);
        tick();
        chk("bb_replays3", perf_replays_a[k], 3);
        chk("bb_fetched", perf_fetched_a[k], 9);

        // Reset while stalled, then clean restart from pc 0
        rstn_a[k] = 1'b0;
        tick();
        rstn_a[k] = 1'b1;
        #1;
        chk("rs_valid", fd_valid_a[k], 0);
        chk("rs_pc", fd_pc_a[k], 0);
        chk("rs_inst", fd_inst_a[k], 0);
        chk("rs_fetched", perf_fetched_a[k], 0);
        chk("rs_replays", perf_replays_a[k], 0);
        chk("rs_stall", stall_a[k], 0);
        de_ready_a[k] = 1'b1;
        for (int c = 1; c <= L + 2; c++) begin
            tick();
            if (c <= L) begin
                chk("rs_bubble", fd_valid_a[k], 0);
            end else begin
                chk("rs_restart_valid", fd_valid_a[k], 1);
                chk("rs_restart_pc", fd_pc_a[k], c - L - 1);
            end
        end
    endtask

    initial begin
        lat[0] = 2; lat[1] = 1; lat[2] = 4;
        for (int k = 0; k < 3; k++) begin
            rip[k] = '0;
            redir[k] = '0;
            for (int j = 0; j < 5; j++) begin
                pq[k][j] = '0;
                ah[k][j] = '0;
            end
            rstn_a[k] = 1'b0;
            flush_a[k] = 1'b0;
            de_ready_a[k] = 1'b1;
        end
        drive();
        tick(); tick();
        for (int k = 0; k < 3; k++) rstn_a[k] = 1'b1;

        run_basic(0);
        run_basic(1);
        run_basic(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
